// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one external SRAM port between
// instruction fetch (port 0) and data access (port 1), with a watchdog that
// aborts transfers the ram controller never acknowledges.
module sram_arbiter #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_adr,
  input  logic              p0_write,
  input  logic [1:0]        p0_sel,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_adr,
  input  logic              p1_write,
  input  logic [1:0]        p1_sel,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_adr,
  output logic              m_write,
  output logic [1:0]        m_sel,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        grant
);

  localparam bit              WD_EN   = (TIMEOUT != 32'd0);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, ABORT} state_t;

  state_t          state;
  state_t          state_next;
  logic            rr_last;
  logic [TO_W-1:0] watchdog;
  logic            win;
  logic            pick1;
  logic            expire;

  // Arbitration: on a tie the port that did not win last time goes next
  always_comb begin
    win    = p0_req | p1_req;
    pick1  = p1_req & (~p0_req | ~rr_last);
    expire = WD_EN && (watchdog == WD_LAST);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: an ack in the expiry cycle still completes normally
  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (win) state_next = pick1 ? BUSY1 : BUSY0;
      BUSY0, BUSY1: begin
        if (m_ack)       state_next = IDLE;
        else if (expire) state_next = ABORT;
      end
      ABORT:        state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // Latched ram-side request, grant, round-robin pointer and watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req    <= 1'b0;
      m_adr    <= '0;
      m_write  <= 1'b0;
      m_sel    <= 2'b00;
      m_wdata  <= '0;
      grant    <= 2'b00;
      rr_last  <= 1'b1;
      watchdog <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win) begin
            m_adr    <= pick1 ? p1_adr   : p0_adr;
            m_write  <= pick1 ? p1_write : p0_write;
            m_sel    <= pick1 ? p1_sel   : p0_sel;
            m_wdata  <= pick1 ? p1_wdata : p0_wdata;
            m_req    <= 1'b1;
            grant    <= pick1 ? 2'b10 : 2'b01;
            rr_last  <= pick1;
            watchdog <= '0;
          end
        end
        BUSY0, BUSY1: begin
          if (m_ack) begin
            m_req <= 1'b0;
            grant <= 2'b00;
          end else if (WD_EN) begin
            if (expire) m_req <= 1'b0;
            else        watchdog <= watchdog + TO_W'(1);
          end
        end
        ABORT:   grant <= 2'b00;
        default: grant <= 2'b00;
      endcase
    end
  end

  // Requester-side responses: ram ack passes straight through, abort forces an error ack
  always_comb begin
    p0_ack   = 1'b0;
    p0_err   = 1'b0;
    p0_rdata = '0;
    p1_ack   = 1'b0;
    p1_err   = 1'b0;
    p1_rdata = '0;
    case (state)
      BUSY0: begin
        p0_ack   = m_ack;
        p0_rdata = m_rdata;
      end
      BUSY1: begin
        p1_ack   = m_ack;
        p1_rdata = m_rdata;
      end
      ABORT: begin
        p0_ack = grant[0];
        p0_err = grant[0];
        p1_ack = grant[1];
        p1_err = grant[1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_sram_arbiter;

  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned TO_W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              p0_req, p0_write, p0_ack, p0_err;
  logic [ADDR_W-1:0] p0_adr;
  logic [1:0]        p0_sel;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_req, p1_write, p1_ack, p1_err;
  logic [ADDR_W-1:0] p1_adr;
  logic [1:0]        p1_sel;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic              m_req, m_write, m_ack;
  logic [ADDR_W-1:0] m_adr;
  logic [1:0]        m_sel;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [1:0]        grant;

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_adr(p0_adr), .p0_write(p0_write), .p0_sel(p0_sel),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_adr(p1_adr), .p1_write(p1_write), .p1_sel(p1_sel),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .m_req(m_req), .m_adr(m_adr), .m_write(m_write), .m_sel(m_sel),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .grant(grant)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the ram, whether that ownership is in its
  // abort cycle, how many busy cycles went by without an ack, and what was latched
  int                owner;
  bit                aborting;
  int                waited;
  int                last_win;
  bit                new_xfer;
  logic [ADDR_W-1:0] l_adr;
  logic              l_write;
  logic [1:0]        l_sel;
  logic [DATA_W-1:0] l_wdata;
  bit                exp_ack0, exp_ack1;
  int                ack_delay;

  function automatic void model_reset();
    owner    = -1;
    aborting = 1'b0;
    waited   = 0;
    last_win = 1;
    new_xfer = 1'b0;
    l_adr    = '0;
    l_write  = 1'b0;
    l_sel    = 2'b00;
    l_wdata  = '0;
  endfunction

  // Advance the model over one clock edge using the inputs present at that edge
  function automatic void model_update();
    int w;
    if (rst) begin
      model_reset();
    end else if (owner < 0) begin
      if (p0_req || p1_req) begin
        if (p0_req && p1_req) w = 1 - last_win;
        else                  w = p1_req ? 1 : 0;
        owner    = w;
        last_win = w;
        waited   = 0;
        new_xfer = 1'b1;
        l_adr    = w ? p1_adr   : p0_adr;
        l_write  = w ? p1_write : p0_write;
        l_sel    = w ? p1_sel   : p0_sel;
        l_wdata  = w ? p1_wdata : p0_wdata;
      end
    end else if (aborting) begin
      owner    = -1;
      aborting = 1'b0;
    end else if (m_ack) begin
      owner = -1;
    end else begin
      waited++;
      if (TIMEOUT != 0 && waited == int'(TIMEOUT)) aborting = 1'b1;
    end
  endfunction

  // Compare every DUT output against what the model expects this cycle
  task automatic check_cycle();
    logic              e_mreq, e_ack0, e_ack1, e_err0, e_err1;
    logic [1:0]        e_grant;
    logic [DATA_W-1:0] e_rd0, e_rd1;
    e_mreq  = (owner >= 0) && !aborting;
    e_grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e_ack0  = (owner == 0) && (aborting || m_ack);
    e_ack1  = (owner == 1) && (aborting || m_ack);
    e_err0  = (owner == 0) && aborting;
    e_err1  = (owner == 1) && aborting;
    e_rd0   = (owner == 0 && !aborting) ? m_rdata : '0;
    e_rd1   = (owner == 1 && !aborting) ? m_rdata : '0;
    chk("m_req", 32'(m_req), 32'(e_mreq));
    chk("grant", 32'(grant), 32'(e_grant));
    if (e_mreq) begin
      chk("m_adr", 32'(m_adr), 32'(l_adr));
      chk("m_write", 32'(m_write), 32'(l_write));
      chk("m_sel", 32'(m_sel), 32'(l_sel));
      chk("m_wdata", 32'(m_wdata), 32'(l_wdata));
    end
    chk("p0_ack", 32'(p0_ack), 32'(e_ack0));
    chk("p1_ack", 32'(p1_ack), 32'(e_ack1));
    chk("p0_err", 32'(p0_err), 32'(e_err0));
    chk("p1_err", 32'(p1_err), 32'(e_err1));
    chk("p0_rdata", 32'(p0_rdata), 32'(e_rd0));
    chk("p1_rdata", 32'(p1_rdata), 32'(e_rd1));
    exp_ack0 = e_ack0;
    exp_ack1 = e_ack1;
  endtask

  // One cycle: check mid-cycle, advance the model at the edge, return just after it
  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    p0_req = 1'b0; p0_adr = '0; p0_write = 1'b0; p0_sel = 2'b00; p0_wdata = '0;
    p1_req = 1'b0; p1_adr = '0; p1_write = 1'b0; p1_sel = 2'b00; p1_wdata = '0;
    m_ack  = 1'b0; m_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  // Random requesters hold req until acked, sometimes re-request back to back;
  // the ram acks after a random delay, sometimes never, sometimes late in the abort cycle
  task automatic drive_random();
    if (p0_req && exp_ack0) p0_req = ($urandom_range(0, 3) == 0);
    else if (!p0_req)       p0_req = ($urandom_range(0, 2) == 0);
    if (p1_req && exp_ack1) p1_req = ($urandom_range(0, 3) == 0);
    else if (!p1_req)       p1_req = ($urandom_range(0, 2) == 0);
    p0_adr = ADDR_W'($urandom); p0_write = 1'($urandom); p0_sel = 2'($urandom);
    p0_wdata = DATA_W'($urandom);
    p1_adr = ADDR_W'($urandom); p1_write = 1'($urandom); p1_sel = 2'($urandom);
    p1_wdata = DATA_W'($urandom);
    if (new_xfer) begin
      ack_delay = $urandom_range(0, 10);
      new_xfer  = 1'b0;
    end
    m_ack   = ((owner >= 0) && !aborting && (waited == ack_delay)) ||
              (aborting && ($urandom_range(0, 1) == 1));
    m_rdata = DATA_W'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: bench did not finish within time limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    ack_delay = 0;
    step();
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_m_adr", 32'(m_adr), 32'd0);
    chk("rst_m_wdata", 32'(m_wdata), 32'd0);
    chk("rst_m_sel", 32'(m_sel), 32'd0);
    chk("rst_m_write", 32'(m_write), 32'd0);
    step();
    rst = 1'b0;

    // Test 1: p0 read alone, ram acks 3 cycles after m_req
    p0_req = 1'b1; p0_adr = 18'h00123; p0_write = 1'b0; p0_sel = 2'b11;
    step();
    chk("t1_mreq_rise", 32'(m_req), 32'd1);
    chk("t1_m_adr", 32'(m_adr), 32'h00123);
    repeat (3) step();
    m_ack = 1'b1; m_rdata = 16'hBEEF;
    #1;
    chk("t1_p0_ack", 32'(p0_ack), 32'd1);
    chk("t1_p0_rdata", 32'(p0_rdata), 32'hBEEF);
    chk("t1_p1_ack", 32'(p1_ack), 32'd0);
    step();
    m_ack = 1'b0; m_rdata = '0; p0_req = 1'b0;
    chk("t1_mreq_low", 32'(m_req), 32'd0);
    step();

    // Test 2: both ports request continuously from reset; grants alternate
    do_reset();
    p0_req = 1'b1; p0_adr = 18'h11111;
    p1_req = 1'b1; p1_adr = 18'h22222;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t2_grant%0d", k), 32'(grant), (k % 2 == 1) ? 32'd2 : 32'd1);
      chk($sformatf("t2_m_adr%0d", k), 32'(m_adr), (k % 2 == 1) ? 32'h22222 : 32'h11111);
      m_ack = 1'b1; m_rdata = DATA_W'($urandom);
      step();
      m_ack = 1'b0;
    end
    clear_inputs();
    step();

    // Test 3: p1 write; requester inputs change mid-transfer and are ignored
    p1_req = 1'b1; p1_adr = 18'h3FFFF; p1_write = 1'b1; p1_sel = 2'b10; p1_wdata = 16'hA55A;
    step();
    p1_wdata = '0; p1_adr = '0; p1_sel = 2'b01; p1_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t3_m_wdata%0d", k), 32'(m_wdata), 32'hA55A);
      chk($sformatf("t3_m_sel%0d", k), 32'(m_sel), 32'd2);
      chk($sformatf("t3_m_adr%0d", k), 32'(m_adr), 32'h3FFFF);
      step();
    end
    m_ack = 1'b1;
    #1;
    chk("t3_p1_ack", 32'(p1_ack), 32'd1);
    chk("t3_m_wdata_ack", 32'(m_wdata), 32'hA55A);
    step();
    clear_inputs();
    step();

    // Test 4: ram never acks; watchdog aborts after TIMEOUT cycles
    p0_req = 1'b1; p0_adr = 18'h00444;
    step();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!m_req) break;
      cnt++;
      step();
    end
    chk("t4_mreq_cycles", 32'(cnt), 32'(TIMEOUT));
    m_ack = 1'b1; m_rdata = 16'hFFFF;
    #1;
    chk("t4_abort_ack", 32'(p0_ack), 32'd1);
    chk("t4_abort_err", 32'(p0_err), 32'd1);
    chk("t4_abort_rdata", 32'(p0_rdata), 32'd0);
    chk("t4_abort_grant", 32'(grant), 32'd1);
    step();
    m_ack = 1'b0; m_rdata = '0; p0_req = 1'b0;
    chk("t4_idle_ack", 32'(p0_ack), 32'd0);
    chk("t4_idle_grant", 32'(grant), 32'd0);
    step();

    // Test 5: ack lands exactly on the watchdog expiry cycle
    p0_req = 1'b1; p0_adr = 18'h00555;
    step();
    repeat (TIMEOUT - 1) step();
    m_ack = 1'b1; m_rdata = 16'h1234;
    #1;
    chk("t5_ack", 32'(p0_ack), 32'd1);
    chk("t5_err", 32'(p0_err), 32'd0);
    chk("t5_rdata", 32'(p0_rdata), 32'h1234);
    step();
    m_ack = 1'b0; p0_req = 1'b0;
    chk("t5_no_abort_ack", 32'(p0_ack), 32'd0);
    chk("t5_mreq_low", 32'(m_req), 32'd0);
    step();

    // Test 6: async reset mid-BUSY1, then p0 wins the first tie
    p1_req = 1'b1; p1_adr = 18'h00666;
    step();
    step();
    chk("t6_busy1_grant", 32'(grant), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_mreq", 32'(m_req), 32'd0);
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_p1_ack", 32'(p1_ack), 32'd0);
    model_reset();
    p0_req = 1'b1; p0_adr = 18'h00777;
    step();
    rst = 1'b0;
    step();
    chk("t6_first_grant", 32'(grant), 32'd1);
    chk("t6_first_adr", 32'(m_adr), 32'h00777);
    m_ack = 1'b1;
    step();
    clear_inputs();
    step();

    // Randomized traffic against the reference model
    do_reset();
    exp_ack0 = 1'b0;
    exp_ack1 = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      drive_random();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Two-requester arbiter that shares the single external-SRAM access port of the ram controller (adr/req/ack/write/sel/rdata/wdata) between core instruction fetch (port 0) and core data access (port 1). It uses round-robin arbitration and latches each granted request so the ram side sees stable signals. A watchdog aborts any transfer the ram controller does not acknowledge within TIMEOUT cycles. The arbiter sits between core and ram in the top level.

Parameters:
ADDR_W, 18, SRAM word-address width
DATA_W, 16, SRAM data width
TIMEOUT, 255, max cycles to wait for m_ack; 0 disables the watchdog
TO_W, 8, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
p0_req  in  1  port 0 request, level; held until p0_ack
p0_adr  in  ADDR_W  port 0 address
p0_write  in  1  port 0 write=1 / read=0
p0_sel  in  2  port 0 byte lanes {UB,LB}
p0_wdata  in  DATA_W  port 0 write data
p0_ack  out  1  port 0 completion pulse
p0_err  out  1  port 0 timeout flag, valid with p0_ack
p0_rdata  out  DATA_W  port 0 read data, valid with p0_ack
p1_req, p1_adr, p1_write, p1_sel, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0
m_req  out  1  request to ram controller
m_adr  out  ADDR_W  latched address
m_write  out  1  latched write flag
m_sel  out  2  latched byte lanes
m_wdata  out  DATA_W  latched write data
m_ack  in  1  ram completion pulse, one cycle
m_rdata  in  DATA_W  ram read data, valid with m_ack
grant  out  2  one-hot owner {p1,p0}; 00 when idle

Behaviour:
- Reset (async, immediate): state=IDLE; m_req=0; m_adr/m_write/m_sel/m_wdata=0; grant=00; all pN_ack/pN_err=0; rr_last=1, so port 0 wins the first tie; watchdog=0.
- States: IDLE, BUSY0, BUSY1, ABORT.
- IDLE, at the clock edge:
  - Only one req high: that port wins.
  - Both high: the port != rr_last wins.
  - On a win: latch that port's adr/write/sel/wdata into the m_* registers; set m_req=1; set grant; go to BUSYn; rr_last=n; watchdog=0.
  - m_req asserts in the cycle after the req is sampled, so there is 1 cycle of arbitration latency.
- BUSYn:
  - m_req stays 1 and the m_* signals stay constant. Changes on the requester inputs are ignored.
  - pn_ack = m_ack (combinational). pn_rdata = m_rdata. pn_err=0.
  - On m_ack: at the next edge m_req=0, grant=00, state=IDLE.
  - Otherwise, if TIMEOUT!=0, watchdog increments. When watchdog==TIMEOUT-1 with no m_ack: m_req=0 at the next edge and state=ABORT.
  - m_ack in the same cycle as watchdog expiry counts as normal completion; the ack wins.
- ABORT (exactly 1 cycle): pn_ack=1, pn_err=1, pn_rdata=0 for the aborted port; grant is held; any m_ack is ignored. Next state is IDLE.
- The non-granted port always sees ack=0, err=0, rdata=0.
- Requester rule: drop req in the cycle after ack. A req still high in IDLE after that is a new request, so back-to-back requests are allowed.
  - With both ports requesting continuously, grants strictly alternate.
- m_req is low for at least 1 cycle between transfers (the IDLE cycle); the ram controller relies on this.
- Reset during BUSY or ABORT: the transfer is dropped silently; no ack is issued; m_req falls asynchronously.
- pN_* inputs are assumed synchronous to clk.

Test Plan:
1. p0 read alone, adr=0x00123; ram acks 3 cycles after m_req with m_rdata=0xBEEF -> m_req rises 1 cycle after p0_req; p0_ack=1 with p0_rdata=0xBEEF; m_req low the next cycle; p1_ack never pulses.
2. p0 and p1 raised together from reset and held continuously -> grants go p0, p1, p0, p1; m_adr each time matches the granted port's address.
3. p1 write adr=0x3FFFF, sel=2'b10, wdata=0xA55A; p1 changes wdata to 0 mid-transfer -> m_wdata stays 0xA55A until m_ack; m_sel=10 throughout.
4. TIMEOUT=8, ram never acks -> m_req high for exactly 8 cycles, then p0_ack=1 and p0_err=1 for 1 cycle; arbiter returns to IDLE; a late m_ack in the ABORT cycle produces no extra ack.
5. m_ack arrives on the watchdog expiry cycle (cycle 8) -> normal ack with err=0 and the ram data; no ABORT state.
6. Assert rst mid-BUSY1 -> m_req and grant drop immediately; no p1_ack; after release, p0 and p1 both requesting gives p0 the grant first.
